// File: rtl/bcd_pkg.sv
// Shared types and constants for the signed-binary to packed-BCD formatter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } bcd_state_e;

    localparam int         BCD_MAX  = 999;
    localparam int         BCD_ITER = 10;
    localparam int         BIN_W    = 10;
    localparam int         ACC_W    = 12;
    localparam logic [3:0] SIGN_NEG = 4'd1;
    localparam logic [3:0] SIGN_POS = 4'd0;

    // Double-dabble digit correction applied before each left shift.
    function automatic logic [3:0] add3_nibble(input logic [3:0] d);
        logic [3:0] q;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end else begin
            q = d;
        end
        return q;
    endfunction

endpackage

// File: rtl/bcd_formatter_if.sv
// Handshake and result bundle of bcd_formatter; ovf exists only when BCD_SAT_EN is defined.
interface bcd_formatter_if #(parameter int IN_W = 12);
    logic [IN_W-1:0] in_value;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     data;
    logic            out_valid;
`ifdef BCD_SAT_EN
    logic            ovf;

    modport master (output in_value, in_valid, input in_ready, data, out_valid, ovf);
    modport slave  (input in_value, in_valid, output in_ready, data, out_valid, ovf);
`else
    modport master (output in_value, in_valid, input in_ready, data, out_valid);
    modport slave  (input in_value, in_valid, output in_ready, data, out_valid);
`endif
endinterface

// File: rtl/bcd_formatter_add3.sv
// Combinational BCD nibble correction: digits of 5 or more get +3 ahead of the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = add3_nibble(d);
endmodule

// File: rtl/bcd_formatter.sv
// Iterative signed-binary (tenths) to {sign, tens, units, tenths} BCD converter.
// Define BCD_SAT_EN to clamp out-of-range inputs to +/-99.9 and flag them on ovf.
module bcd_formatter
    import bcd_pkg::*;
#(
    parameter int IN_W = 12
) (
    input  logic           clk,
    input  logic           rstn,
    bcd_formatter_if.slave bus
);

    bcd_state_e       state_r;
    bcd_state_e       state_nxt_s;
    logic [IN_W-1:0]  in_reg_r;
    logic [BIN_W-1:0] bin_r;
    logic [ACC_W-1:0] acc_r;
    logic [3:0]       cnt_r;
    logic             neg_r;
    logic [15:0]      data_r;
    logic             out_valid_r;
`ifdef BCD_SAT_EN
    logic             oor_r;
    logic             ovf_r;
`endif

    logic                   accept_s;
    logic                   neg_s;
    logic [IN_W:0]          ext_s;
    logic [IN_W:0]          mag_s;
    logic                   oor_s;
    logic [BIN_W-1:0]       mag_fin_s;
    logic [ACC_W-1:0]       acc_adj_s;
    logic [ACC_W+BIN_W-1:0] shifted_s;

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.data      = data_r;
    assign bus.out_valid = out_valid_r;
`ifdef BCD_SAT_EN
    assign bus.ovf       = ovf_r;
`endif

    assign accept_s = bus.in_valid && (state_r == IDLE);

    // Sign/magnitude split; one extra bit so the most negative input negates cleanly.
    always_comb begin
        neg_s = in_reg_r[IN_W-1];
        ext_s = {in_reg_r[IN_W-1], in_reg_r};
        if (neg_s) begin
            mag_s = ~ext_s + (IN_W+1)'(1);
        end else begin
            mag_s = ext_s;
        end
        oor_s = (mag_s > (IN_W+1)'(BCD_MAX));
        if (oor_s) begin
`ifdef BCD_SAT_EN
            mag_fin_s = BIN_W'(BCD_MAX);
`else
            mag_fin_s = {BIN_W{1'b0}};
`endif
        end else begin
            mag_fin_s = mag_s[BIN_W-1:0];
        end
    end

    bcd_add3 u_add3_tenths (.d(acc_r[3:0]),  .q(acc_adj_s[3:0]));
    bcd_add3 u_add3_units  (.d(acc_r[7:4]),  .q(acc_adj_s[7:4]));
    bcd_add3 u_add3_tens   (.d(acc_r[11:8]), .q(acc_adj_s[11:8]));

    assign shifted_s = {acc_adj_s, bin_r} << 1;

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: state_nxt_s = SHIFT;
            SHIFT: begin
                if (cnt_r == 4'(BCD_ITER - 1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Conversion datapath and held output word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_reg_r    <= '0;
            bin_r       <= '0;
            acc_r       <= '0;
            cnt_r       <= 4'd0;
            neg_r       <= 1'b0;
            data_r      <= 16'h0000;
            out_valid_r <= 1'b0;
`ifdef BCD_SAT_EN
            oor_r       <= 1'b0;
            ovf_r       <= 1'b0;
`endif
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        in_reg_r <= bus.in_value;
                    end
                end
                LOAD: begin
                    bin_r <= mag_fin_s;
                    acc_r <= '0;
                    cnt_r <= 4'd0;
                    // Zero never carries a minus sign, including clamped-to-zero results.
                    neg_r <= neg_s && (mag_fin_s != {BIN_W{1'b0}});
`ifdef BCD_SAT_EN
                    oor_r <= oor_s;
`endif
                end
                SHIFT: begin
                    acc_r <= shifted_s[ACC_W+BIN_W-1:BIN_W];
                    bin_r <= shifted_s[BIN_W-1:0];
                    cnt_r <= cnt_r + 4'd1;
                end
                DONE: begin
                    data_r      <= {(neg_r ? SIGN_NEG : SIGN_POS), acc_r};
                    out_valid_r <= 1'b1;
`ifdef BCD_SAT_EN
                    ovf_r       <= oor_r;
`endif
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_formatter.sv
// Scoreboard bench for bcd_formatter: directed vectors, queue of expected words, negedge monitor.
module tb_bcd_formatter;

    localparam int IN_W = 12;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    logic [16:0] sb[$];
    time  t_acc;
    time  t_ov;
    logic prev_ov;

    bcd_formatter_if #(.IN_W(IN_W)) bus ();

    bcd_formatter #(.IN_W(IN_W)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_ovf();
`ifdef BCD_SAT_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: pops the scoreboard on every out_valid pulse.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.out_valid) begin
                logic [16:0] exp;
                t_ov = $time;
                checks++;
                if (prev_ov) begin
                    errors++;
                    $display("FAIL out_valid_double actual=1 required=0 at %0t", $time);
                end
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out_valid data=%h at %0t", bus.data, $time);
                end else begin
                    exp = sb.pop_front();
                    if (bus.data !== exp[15:0] || get_ovf() !== exp[16]) begin
                        errors++;
                        $display("FAIL result data=%h ovf=%b required data=%h ovf=%b",
                                 bus.data, get_ovf(), exp[15:0], exp[16]);
                    end
                end
            end
            prev_ov = bus.out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    task automatic send(input int v, input logic [16:0] exp, input logic push);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        bus.in_value = IN_W'(v);
        bus.in_valid = 1'b1;
        if (push) sb.push_back(exp);
        @(posedge clk);
        t_acc = $time;
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, sb.size());
        end
    endtask

    task automatic check_latency(input string name);
        checks++;
        if (t_ov - t_acc != 125) begin
            errors++;
            $display("FAIL %s_latency actual=%0t required=125", name, t_ov - t_acc);
        end
    endtask

    initial begin
        time t0;
        time t1;
        int  n;
        checks = 0;
        errors = 0;
        prev_ov = 1'b0;
        t_ov = 0;
        rstn = 1'b0;
        bus.in_value = '0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.data !== 16'h0000 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || get_ovf() !== 1'b0) begin
            errors++;
            $display("FAIL reset_state data=%h ov=%b rdy=%b ovf=%b required 0000/0/1/0",
                     bus.data, bus.out_valid, bus.in_ready, get_ovf());
        end
        @(negedge clk);
        rstn = 1'b1;

        send(123, {1'b0, 16'h0123}, 1'b1);
        drain("v123");
        check_latency("v123");
        send(-57, {1'b0, 16'h1057}, 1'b1);
        drain("vm57");
        check_latency("vm57");
        send(0, {1'b0, 16'h0000}, 1'b1);
        drain("v0");

        // Back-to-back with in_valid held high: accepts 13 clocks apart.
        @(negedge clk);
        bus.in_value = IN_W'(999);
        bus.in_valid = 1'b1;
        sb.push_back({1'b0, 16'h0999});
        @(posedge clk);
        t0 = $time;
        #1 bus.in_value = IN_W'(-999);
        sb.push_back({1'b0, 16'h1999});
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        t1 = $time;
        #1 bus.in_valid = 1'b0;
        checks++;
        if (t1 - t0 != 130) begin
            errors++;
            $display("FAIL accept_spacing actual=%0t required=130", t1 - t0);
        end
        drain("b2b");

`ifdef BCD_SAT_EN
        send(1500, {1'b1, 16'h0999}, 1'b1);
        drain("v1500");
        send(-2048, {1'b1, 16'h1999}, 1'b1);
        drain("vm2048");
        send(5, {1'b0, 16'h0005}, 1'b1);
        drain("v5");
`else
        send(1500, {1'b0, 16'h0000}, 1'b1);
        drain("v1500");
        send(-2048, {1'b0, 16'h0000}, 1'b1);
        drain("vm2048");
`endif

        // Reset mid-conversion: no pulse for the aborted value.
        send(456, {1'b0, 16'h0456}, 1'b0);
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (bus.data !== 16'h0000 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset data=%h rdy=%b ov=%b required 0000/1/0",
                     bus.data, bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.data !== 16'h0000 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_abort data=%h rdy=%b required 0000/1", bus.data, bus.in_ready);
        end
        send(456, {1'b0, 16'h0456}, 1'b1);
        drain("v456");

        // Hold: data stable while in_value toggles with in_valid low.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bus.in_value = IN_W'($urandom_range(0, 4095));
            checks++;
            if (bus.data !== 16'h0456 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold data=%h ov=%b required 0456/0", bus.data, bus.out_valid);
            end
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
